// File: rtl/prom_access_arbiter_if.sv
// rtl/prom_access_arbiter_if.sv - requester and PROM signal bundle for prom_access_arbiter
interface prom_access_arbiter_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 2
);
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              prom_en;
  logic [ADDR_W-1:0] prom_addr;
  logic [DATA_W-1:0] prom_data;

  modport slave (
    input  req0, addr0, req1, addr1, prom_data,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, prom_en, prom_addr
  );

  modport master (
    output req0, addr0, req1, addr1, prom_data,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, prom_en, prom_addr
  );
endinterface

// File: rtl/prom_access_arbiter.sv
// rtl/prom_access_arbiter.sv - two-requester round-robin arbiter and PROM access sequencer
module prom_access_arbiter #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  prom_access_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state, state_next;
  logic              win, win_next;
  logic              prio, prio_next;
  logic              pick;
  logic              gnt0_q, gnt1_q, rvalid0_q, rvalid1_q, prom_en_q;
  logic              gnt0_n, gnt1_n, rvalid0_n, rvalid1_n, prom_en_n;
  logic [ADDR_W-1:0] prom_addr_q, prom_addr_n;
  logic [DATA_W-1:0] rdata_q, rdata_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      win         <= 1'b0;
      prio        <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      prom_en_q   <= 1'b0;
      prom_addr_q <= '0;
      rdata_q     <= '0;
    end else begin
      state       <= state_next;
      win         <= win_next;
      prio        <= prio_next;
      gnt0_q      <= gnt0_n;
      gnt1_q      <= gnt1_n;
      rvalid0_q   <= rvalid0_n;
      rvalid1_q   <= rvalid1_n;
      prom_en_q   <= prom_en_n;
      prom_addr_q <= prom_addr_n;
      rdata_q     <= rdata_n;
    end
  end

  // Outputs are computed for the next state and registered, so they carry no
  // combinational path from req/addr.
  always_comb begin
    state_next  = state;
    win_next    = win;
    prio_next   = prio;
    rdata_n     = rdata_q;
    pick        = 1'b0;
    gnt0_n      = 1'b0;
    gnt1_n      = 1'b0;
    rvalid0_n   = 1'b0;
    rvalid1_n   = 1'b0;
    prom_en_n   = 1'b0;
    prom_addr_n = '0;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          pick        = (bus.req0 && bus.req1) ? prio : bus.req1;
          win_next    = pick;
          state_next  = ACCESS;
          gnt0_n      = ~pick;
          gnt1_n      = pick;
          prom_en_n   = 1'b1;
          prom_addr_n = pick ? bus.addr1 : bus.addr0;
        end
      end
      ACCESS: begin
        rdata_n    = bus.prom_data;
        prio_next  = ~win;
        state_next = DONE;
        rvalid0_n  = ~win;
        rvalid1_n  = win;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.rvalid0   = rvalid0_q;
  assign bus.rvalid1   = rvalid1_q;
  assign bus.rdata     = rdata_q;
  assign bus.prom_en   = prom_en_q;
  assign bus.prom_addr = prom_addr_q;
endmodule

// File: tb/tb_prom_access_arbiter.sv
// tb/tb_prom_access_arbiter.sv - directed self-checking bench for prom_access_arbiter
module tb_prom_access_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prom_access_arbiter_if #(.ADDR_W(2), .DATA_W(2)) bus();
  prom_access_arbiter #(.ADDR_W(2), .DATA_W(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // PROM model: 0->01, 1->10, 2->11, 3->00
  logic [1:0] rom_q;
  always_comb begin
    case (bus.prom_addr)
      2'd0:    rom_q = 2'b01;
      2'd1:    rom_q = 2'b10;
      2'd2:    rom_q = 2'b11;
      default: rom_q = 2'b00;
    endcase
  end
  assign bus.prom_data = bus.prom_en ? rom_q : 2'b00;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_grant = -1;
  int overlap = 0;
  logic [1:0] sweep_exp [4] = '{2'b01, 2'b10, 2'b11, 2'b00};

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if ((bus.gnt0 && bus.gnt1) || (bus.rvalid0 && bus.rvalid1)) overlap <= overlap + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return {24'd0, bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.prom_en,
            bus.prom_addr[0], bus.rdata};
  endfunction

  task automatic wait_grant(input int exp_w, input logic [1:0] exp_addr, input int exp_gap,
                            input string tag);
    bit got = 1'b0;
    bit stray = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.gnt0 || bus.gnt1) begin
        got = 1'b1;
        break;
      end
      if (bus.rvalid0 || bus.rvalid1) stray = 1'b1;
    end
    check({tag, "_timeout"}, 32'(got), 32'd1);
    check({tag, "_gnt"}, {30'd0, bus.gnt0, bus.gnt1}, (exp_w == 1) ? 32'd1 : 32'd2);
    check({tag, "_en"}, 32'(bus.prom_en), 32'd1);
    check({tag, "_addr"}, 32'(bus.prom_addr), 32'(exp_addr));
    check({tag, "_stray_rvalid"}, 32'(stray), 32'd0);
    if (exp_gap > 0) check({tag, "_gap"}, 32'(cyc - last_grant), 32'(exp_gap));
    last_grant = cyc;
  endtask

  task automatic finish_access(input int exp_w, input logic [1:0] exp_data, input string tag);
    @(negedge clk);
    check({tag, "_rvalid"}, {30'd0, bus.rvalid0, bus.rvalid1}, (exp_w == 1) ? 32'd1 : 32'd2);
    check({tag, "_rdata"}, 32'(bus.rdata), 32'(exp_data));
    check({tag, "_quiet"}, {28'd0, bus.gnt0, bus.gnt1, bus.prom_en, |bus.prom_addr}, 32'd0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_grant = -1;
  endtask

  initial begin
    int g;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    bus.addr0 = 2'd0;
    bus.addr1 = 2'd0;

    // Reset held with both requesting
    repeat (2) begin
      @(negedge clk);
      check("reset_outputs", out_vec(), 32'd0);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", out_vec(), 32'd0);

    // Single request
    bus.req0 = 1'b1;
    bus.addr0 = 2'd2;
    wait_grant(0, 2'd2, 0, "single");
    bus.req0 = 1'b0;
    finish_access(0, 2'b11, "single");

    // Simultaneous requests after reset alternate 0,1,0,1
    pulse_reset();
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    bus.addr0 = 2'd1;
    bus.addr1 = 2'd3;
    for (int i = 0; i < 4; i++) begin
      wait_grant(i % 2, (i % 2) ? 2'd3 : 2'd1, (i == 0) ? 0 : 3, "rr");
      if (i == 3) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end
      finish_access(i % 2, (i % 2) ? 2'b00 : 2'b10, "rr");
    end

    // Address change and request drop in flight
    bus.req1 = 1'b1;
    bus.addr1 = 2'd0;
    wait_grant(1, 2'd0, 0, "drop");
    bus.addr1 = 2'd3;
    bus.req1 = 1'b0;
    finish_access(1, 2'b01, "drop");
    g = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.gnt0 || bus.gnt1) g++;
    end
    check("drop_no_regrant", 32'(g), 32'd0);

    // Move the pointer to 1, then reset during requester 1's ACCESS
    bus.req0 = 1'b1;
    bus.addr0 = 2'd0;
    wait_grant(0, 2'd0, 0, "pre");
    bus.req0 = 1'b0;
    finish_access(0, 2'b01, "pre");
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    bus.addr0 = 2'd2;
    bus.addr1 = 2'd1;
    wait_grant(1, 2'd1, 0, "rst_mid");
    rst_n = 1'b0;
    #1;
    check("rst_mid_async", out_vec(), 32'd0);
    @(negedge clk);
    check("rst_mid_held", out_vec(), 32'd0);
    rst_n = 1'b1;
    last_grant = -1;
    wait_grant(0, 2'd2, 0, "post_rst");
    finish_access(0, 2'b11, "post_rst");
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;

    // Full address sweep on requester 0
    for (int a = 0; a < 4; a++) begin
      bus.addr0 = 2'(a);
      bus.req0 = 1'b1;
      wait_grant(0, 2'(a), 0, "sweep");
      finish_access(0, sweep_exp[a], "sweep");
    end
    bus.req0 = 1'b0;
    repeat (3) @(negedge clk);

    check("exclusive_pulses", 32'(overlap), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/prom_access_arbiter.md
# prom_access_arbiter

Two-requester round-robin arbiter and access sequencer for the shared PROM function block, which takes a 2-bit address `A` and enable `en` and returns the combinational outputs `F1`/`F2`. Each requester posts an address. The arbiter grants one requester at a time, drives the PROM enable and address for one cycle, registers the returned function bits, and returns them with a one-cycle valid pulse. It sits between the PROM and its client logic, so the PROM never sees contention.

## Interface
- `ADDR_W`, default 2: PROM address width.
- `DATA_W`, default 2: PROM data width. Bit 1 = F1, bit 0 = F2.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req0`  in  1: requester 0 access request, level.
- `addr0`  in  ADDR_W: requester 0 address.
- `req1`  in  1: requester 1 access request, level.
- `addr1`  in  ADDR_W: requester 1 address.
- `gnt0`  out  1: requester 0 granted, one-cycle pulse.
- `gnt1`  out  1: requester 1 granted, one-cycle pulse.
- `rvalid0`  out  1: `rdata` is valid for requester 0, one-cycle pulse.
- `rvalid1`  out  1: `rdata` is valid for requester 1, one-cycle pulse.
- `rdata`  out  DATA_W: registered PROM result.
- `prom_en`  out  1: PROM enable.
- `prom_addr`  out  ADDR_W: PROM address.
- `prom_data`  in  DATA_W: combinational PROM output, concatenated as {F1, F2}.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE**
  - If no request is present, stay in IDLE.
  - If only one requester has its request high, that requester wins.
  - If both are high, the winner is the one indicated by the priority pointer `prio` (0 or 1).
  - On a win: latch the winner's index and address, then go to ACCESS.
- **ACCESS** (one cycle)
  - `prom_en`=1 and `prom_addr`=latched address.
  - The winner's `gnt` is high.
  - At the end of the cycle, capture `prom_data` into `rdata` and set `prio` to the requester that did not win.
  - Go to DONE.
- **DONE** (one cycle)
  - The winner's `rvalid` is high.
  - `rdata` holds the captured value.
  - Go to IDLE.
- Round-robin behaviour:
  - The pointer updates only on a completed grant.
  - A lone requester is served repeatedly regardless of the pointer value.
- Address capture:
  - The address is latched at the IDLE decision edge.
  - Changes to `addr0`/`addr1` after that edge do not affect the transaction in flight.
- Request dropped after the decision: the transaction still completes and `rvalid` is still issued.
- `rdata` holds its last value until the next capture. It is meaningful only while the matching `rvalid` is high.
- Outside ACCESS:
  - `prom_en`=0 and `prom_addr`=0.
  - `gnt0`, `gnt1`, `rvalid0`, `rvalid1` = 0.
- `gnt0`/`gnt1` are never high together. `rvalid0`/`rvalid1` are never high together.

## Timing
- Reset (async assert, sync deassert handled upstream) forces:
  - state=IDLE, `prio`=0.
  - All outputs 0: `gnt*`, `rvalid*`, `rdata`, `prom_en`, `prom_addr`.
- Latency, with the request sampled high in IDLE at edge k:
  - `gnt` and `prom_en` are high in cycle k..k+1.
  - `rvalid` is high in cycle k+1..k+2.
- Throughput: one access per 3 cycles. With requests held continuously, the next decision happens at the edge ending DONE+1 (IDLE is always visited for one cycle).
- Reset asserted during ACCESS or DONE:
  - The transaction is aborted immediately and no `rvalid` is issued for it.
  - After release the block is in IDLE with `prio`=0.
- All outputs are registered. No combinational path from `req*`/`addr*` to any output.
- `prom_data` is sampled only at the edge ending ACCESS. The PROM's combinational delay must fit in one clock period.

## Test plan
PROM model contents: addr 0→2'b01, 1→2'b10, 2→2'b11, 3→2'b00.

- **Reset values:** hold `rst_n`=0 for 2 cycles with both requests high → all outputs remain 0, with no `gnt` and no `prom_en`.
- **Single request:** `req0`=1, `addr0`=2 for one decision → `gnt0` pulse with `prom_addr`=2 and `prom_en`=1, then `rvalid0` pulse with `rdata`=2'b11. `req1` side stays 0 throughout.
- **Simultaneous requests after reset:** `req0`=`req1`=1, `addr0`=1, `addr1`=3, held continuously → grants alternate 0,1,0,1. Results are `rvalid0` with `rdata`=2'b10 and `rvalid1` with `rdata`=2'b00. Grants are 3 cycles apart.
- **Address change and request drop in flight:** `req1`=1, `addr1`=0; after `gnt1`, set `addr1`=3 and `req1`=0 → `rvalid1` still pulses with `rdata`=2'b01, and no further grant follows.
- **Reset mid-transaction:** assert `rst_n`=0 during ACCESS → no `rvalid` for that transaction. After release, with both requesting, the first grant goes to requester 0.
- **Full sweep:** requester 0 requests addresses 0..3 in sequence → `rdata` sequence is 01, 10, 11, 00, each paired with exactly one `rvalid0` pulse.
